// File: rtl/fp16_div_unit.sv
`timescale 1ns/1ps
// fp16_div_unit: iterative IEEE-754 half-precision divider (opA / opB), start/busy/valid responder
// with fixed latency. Define FP16_DIV_SUBNORMAL_EN for subnormal operands and gradual underflow.
module fp16_div_unit #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [EXP_W+MAN_W:0] opA,
   input  logic [EXP_W+MAN_W:0] opB,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 valid,
   output logic                 busy,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact,
   output logic                 invalid,
   output logic                 divZero
);
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int MW    = MAN_W + 1;
   localparam int NITER = MAN_W + 4;
   localparam int XW    = NITER + 1;
   localparam int EW    = EXP_W + 2;
   localparam int CW    = $clog2(NITER);
   localparam logic [EW-1:0]    BIAS  = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0]    EMAX  = EW'((1 << EXP_W) - 1);
   localparam logic [EXP_W-1:0] EONES = '1;
   localparam logic [W-1:0]     QNAN  = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND} state_t;

   typedef struct packed {
      logic          nan;
      logic          inf;
      logic          zero;
      logic [MW-1:0] man;
      logic [EW-1:0] exp;
   } unp_t;

   typedef struct packed {
      logic ovf;
      logic unf;
      logic nx;
      logic nv;
      logic dz;
   } flags_t;

`ifdef FP16_DIV_SUBNORMAL_EN
   localparam int LZW = $clog2(MW + 1);

   function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
      lzc = '0;
      for (int i = 0; i < MW; i++)
         if (m[i]) lzc = LZW'(MW - 1 - i);
   endfunction
`endif

   // Subnormals are normalised here so the divider always sees a leading 1.
   function automatic unp_t unpack(input logic [W-2:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] f;
      unp_t             u;
`ifdef FP16_DIV_SUBNORMAL_EN
      logic [LZW-1:0]   lz;
`endif
      {e, f} = x;
      u.nan  = (e == EONES) && (f != '0);
      u.inf  = (e == EONES) && (f == '0);
`ifdef FP16_DIV_SUBNORMAL_EN
      lz     = lzc({1'b0, f});
      u.zero = (e == '0) && (f == '0);
      if (e == '0) begin
         u.man = {1'b0, f} << lz;
         u.exp = EW'(1) - EW'(lz);
      end else begin
         u.man = {1'b1, f};
         u.exp = EW'(e);
      end
`else
      u.zero = (e == '0);
      u.man  = {1'b1, f};
      u.exp  = EW'(e);
`endif
      return u;
   endfunction

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [W-1:0]          a_q, a_d, b_q, b_d;
   logic                  sign_q, sign_d;
   logic signed [EW-1:0]  e_q, e_d;
   logic [MW-1:0]         mb_q, mb_d;
   logic [MW:0]           r_q, r_d;
   logic [NITER-1:0]      q_q, q_d;
   logic                  sp_q, sp_d, sp_nv_q, sp_nv_d, sp_dz_q, sp_dz_d;
   logic [W-1:0]          sp_res_q, sp_res_d;
   logic [W-1:0]          res_q, res_d;
   logic                  valid_q, valid_d;
   flags_t                flags_q, flags_d;

   unp_t                  ua, ub;
   logic                  sgn;

   assign ua  = unpack(a_q[W-2:0]);
   assign ub  = unpack(b_q[W-2:0]);
   assign sgn = a_q[W-1] ^ b_q[W-1];

   // Rounding datapath, evaluated from the settled quotient while in ROUND.
   logic                  norm, tiny, guard, sticky, lost, nx;
   logic [NITER-1:0]      qn;
   logic signed [EW-1:0]  er, ef;
   logic [XW-1:0]         x, xs;
   logic [MW-1:0]         kept;
   logic [MW:0]           rnd;
   logic [W-1:0]          rnd_res;
   flags_t                rnd_flags;
`ifdef FP16_DIV_SUBNORMAL_EN
   logic [EW-1:0]         sh;
`endif

   always_comb begin
      norm = q_q[NITER-1];
      qn   = norm ? q_q : {q_q[NITER-2:0], 1'b0};
      er   = norm ? e_q : e_q - EW'(1);
      x    = {qn, |r_q};
      tiny = er[EW-1] || (er == '0);
`ifdef FP16_DIV_SUBNORMAL_EN
      // Denormalise tiny results so rounding happens at the subnormal LSB.
      sh   = tiny ? EW'(EW'(1) - er) : '0;
      xs   = x >> sh;
      lost = |(x & ~({XW{1'b1}} << sh));
`else
      xs   = x;
      lost = 1'b0;
`endif
      kept      = xs[XW-1 -: MW];
      guard     = xs[XW-1-MW];
      sticky    = (|xs[XW-2-MW:0]) | lost;
      rnd       = {1'b0, kept} + (MW+1)'(guard & (sticky | kept[0]));
      nx        = guard | sticky;
      ef        = er + EW'(rnd[MW]);
      rnd_flags = '0;
      rnd_res   = {sign_q, ef[EXP_W-1:0], rnd[MW] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0]};
      if (tiny) begin
`ifdef FP16_DIV_SUBNORMAL_EN
         // A carry into the hidden position lands in the exponent field: min normal.
         rnd_res       = {sign_q, (W-1)'(rnd[MW-1:0])};
         rnd_flags.unf = nx;
         rnd_flags.nx  = nx;
`else
         rnd_res       = {sign_q, {(W-1){1'b0}}};
         rnd_flags.unf = 1'b1;
         rnd_flags.nx  = 1'b1;
`endif
      end else if (ef >= EMAX) begin
         rnd_res       = {sign_q, EONES, {MAN_W{1'b0}}};
         rnd_flags.ovf = 1'b1;
         rnd_flags.nx  = 1'b1;
      end else begin
         rnd_flags.nx  = nx;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      e_d      = e_q;
      mb_d     = mb_q;
      r_d      = r_q;
      q_d      = q_q;
      sp_d     = sp_q;
      sp_nv_d  = sp_nv_q;
      sp_dz_d  = sp_dz_q;
      sp_res_d = sp_res_q;
      res_d    = res_q;
      flags_d  = flags_q;
      valid_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = opA;
               b_d     = opB;
               flags_d = '0;
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            sign_d  = sgn;
            e_d     = ua.exp - ub.exp + BIAS;
            mb_d    = ub.man;
            r_d     = {1'b0, ua.man};
            q_d     = '0;
            cnt_d   = CW'(NITER - 1);
            sp_d    = 1'b1;
            sp_nv_d = 1'b0;
            sp_dz_d = 1'b0;
            // Specials still run the full divide so latency never depends on operands.
            if (ua.nan || ub.nan || (ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
               sp_res_d = QNAN;
               sp_nv_d  = 1'b1;
            end else if (ua.inf) begin
               sp_res_d = {sgn, EONES, {MAN_W{1'b0}}};
            end else if (ub.zero) begin
               sp_res_d = {sgn, EONES, {MAN_W{1'b0}}};
               sp_dz_d  = 1'b1;
            end else if (ub.inf || ua.zero) begin
               sp_res_d = {sgn, {(W-1){1'b0}}};
            end else begin
               sp_d = 1'b0;
            end
            state_d = S_DIVIDE;
         end
         S_DIVIDE: begin
            if (r_q >= {1'b0, mb_q}) begin
               r_d = (r_q - {1'b0, mb_q}) << 1;
               q_d = {q_q[NITER-2:0], 1'b1};
            end else begin
               r_d = r_q << 1;
               q_d = {q_q[NITER-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = S_ROUND;
         end
         S_ROUND: begin
            valid_d = 1'b1;
            state_d = S_IDLE;
            if (sp_q) begin
               res_d      = sp_res_q;
               flags_d    = '0;
               flags_d.nv = sp_nv_q;
               flags_d.dz = sp_dz_q;
            end else begin
               res_d   = rnd_res;
               flags_d = rnd_flags;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         e_q      <= '0;
         mb_q     <= '0;
         r_q      <= '0;
         q_q      <= '0;
         sp_q     <= 1'b0;
         sp_nv_q  <= 1'b0;
         sp_dz_q  <= 1'b0;
         sp_res_q <= '0;
         res_q    <= '0;
         valid_q  <= 1'b0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         e_q      <= e_d;
         mb_q     <= mb_d;
         r_q      <= r_d;
         q_q      <= q_d;
         sp_q     <= sp_d;
         sp_nv_q  <= sp_nv_d;
         sp_dz_q  <= sp_dz_d;
         sp_res_q <= sp_res_d;
         res_q    <= res_d;
         valid_q  <= valid_d;
         flags_q  <= flags_d;
      end
   end

   assign result    = res_q;
   assign valid     = valid_q;
   assign busy      = (state_q != S_IDLE);
   assign overflow  = flags_q.ovf;
   assign underflow = flags_q.unf;
   assign inexact   = flags_q.nx;
   assign invalid   = flags_q.nv;
   assign divZero   = flags_q.dz;

endmodule

// File: doc/fp16_div_unit.md
Name: fp16_div_unit

Overview:
- Iterative IEEE-754 half-precision (1-5-10) divider, computing result = opA / opB.
- Acts as the responder on the CPU's start/busy/valid coprocessor handshake. It is the multi-cycle engine the CPU stalls on for FPU op 2'b11 (divide).
- Fixed latency for every operand class, so the CPU's stall counter stays deterministic.
- Sits in the Execution stage. Its result feeds the ALU/FPU output mux.

Parameters:
EXP_W, 5, exponent width; bias = 2^(EXP_W-1)-1 = 15.
MAN_W, 10, stored fraction width. Iteration count NITER = MAN_W+4 (=14).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
opA  input  16  dividend (FP16).
opB  input  16  divisor (FP16).
result  output  16  quotient; held from valid pulse until next accepted start.
valid  output  1  one-cycle pulse: result and flags are new.
busy  output  1  high while an operation is in flight.
overflow  output  1  result rounded beyond max finite.
underflow  output  1  result tiny and inexact.
inexact  output  1  rounded result differs from exact quotient.
invalid  output  1  0/0, inf/inf, or any NaN operand.
divZero  output  1  finite nonzero / zero.

Behaviour:
- Reset (async, immediate): state=IDLE; result, valid, busy and all flags = 0. Applies mid-operation: the in-flight op is discarded and no valid pulse is produced.
- FSM: IDLE -> UNPACK -> DIVIDE (NITER cycles, counter NITER-1 down to 0) -> ROUND -> IDLE.
- Accept: at a clock edge with state=IDLE and start=1, latch opA/opB. busy=1 from that edge. State goes to UNPACK.
- start while busy=1 is ignored; operand latches do not change.
- Latency: valid=1 and busy=0 at edge MAN_W+6 (=16) after the accepting edge. valid drops the next edge.
- Back-to-back: a start sampled at the edge where valid rises is not accepted, because busy=1 is the pre-edge value. It is accepted at the following edge.
- UNPACK:
  - sign = sA ^ sB.
  - Mantissa = {hidden 1, fraction}.
  - Exponent difference e = eA - eB + 15, in a signed (EXP_W+2)-bit value.
  - Classify NaN / inf / zero / subnormal.
- DIVIDE: restoring radix-2 division of the 11-bit mantissas, one quotient bit per cycle, MSB first. Produces a 14-bit quotient q in (0.5, 2).
- ROUND:
  - If q[13]=0: shift q left 1 and set e = e-1.
  - guard = next bit after the 11 kept bits; round = the bit after that; sticky = round | (remainder != 0).
  - Round to nearest, ties to even.
  - A mantissa carry-out increments e.
- Exponent limits:
  - e >= 31 -> ±inf (sign, 5'h1F, 0); overflow=1, inexact=1.
  - e <= 0 -> tiny result; handling per Optional Feature.
- Special cases, still at full fixed latency:
  - Any NaN, 0/0 or inf/inf -> 16'h7E00, invalid=1.
  - x/0 with x finite nonzero -> ±inf, divZero=1.
  - inf/finite -> ±inf.
  - finite/inf -> ±0.
  - 0/nonzero -> ±0.
  - All flags other than the one named = 0.
- Flags are registered with result at the valid edge and held until the next accepted start. At the accepting edge, flags and valid clear; result is retained.

Optional Feature:
Macro FP16_DIV_SUBNORMAL_EN.
- Defined: subnormal inputs are normalised in UNPACK using a leading-zero count (still 1 cycle). Tiny results are denormalised with a right shift before rounding, giving gradual underflow. underflow=1 only if the result is tiny and inexact. Rounding up to min normal yields 16'h0400.
- Undefined: subnormal inputs are treated as ±0. Any tiny result flushes to signed zero with underflow=1 and inexact=1.

Test Plan:
- opA=16'h3C00, opB=16'h4000, start pulse -> result=16'h3800 with valid at edge 16; busy=1 for edges 0..15; all flags 0.
- opA=16'h3C00, opB=16'h4200 (1/3) -> result=16'h3555, inexact=1, others 0.
- opA=16'h7BFF, opB=16'h2C00 -> result=16'h7C00, overflow=1, inexact=1. Separately, 16'hC000/16'h0000 -> 16'hFC00 with divZero=1; 16'h0000/16'h0000 -> 16'h7E00 with invalid=1.
- opA=16'h0400, opB=16'h4800:
  - Macro defined -> 16'h0080, flags 0.
  - Macro undefined -> 16'h0000, underflow=1, inexact=1.
- Start 1.0/2.0; re-assert start with other operands at edges 3..15 -> ignored, result=16'h3800. Then start 16'h4400/16'h4000 at edge 17 -> 16'h4000 at edge 33.
- Start, then assert reset at edge 5 -> busy, valid, result and flags = 0 immediately, with no valid pulse later. A start after reset release completes normally at +16.
